// File: rtl/pipe_pkg.sv
// Pipeline-wide constants shared by the ID-stage hazard logic.
package pipe_pkg;

    localparam int unsigned SB_LAT_W = 3;
    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;
    localparam int unsigned LAT_MUL  = 4;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: cycles remaining until the register's pending result is forwardable.
module sb_entry #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LAT_W-1:0] lat,
    output logic [LAT_W-1:0] cnt,
    output logic             zero_c
);

    // A new producer's latency overrides the running countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= lat;
        end else if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/scoreboard_stall_unit.sv
// Register scoreboard for the ID stage: detects RAW/WAW hazards against in-flight
// producers, generates the pipeline stall and counts stalled cycles.
module scoreboard_stall_unit
    import pipe_pkg::*;
#(
    parameter int unsigned NREG  = 32,
    parameter int unsigned LAT_W = SB_LAT_W,
    parameter int unsigned CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [$clog2(NREG)-1:0]   id_rs_addr,
    input  logic [$clog2(NREG)-1:0]   id_rt_addr,
    input  logic                      id_rs_used,
    input  logic                      id_rt_used,
    input  logic                      id_wr_en,
    input  logic [$clog2(NREG)-1:0]   id_wr_addr,
    input  logic [LAT_W-1:0]          id_lat,
    input  logic                      id_flush,
    output logic                      stall,
    output logic                      rs_hazard,
    output logic                      rt_hazard,
    output logic                      waw_hazard,
    output logic                      busy,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int unsigned AW = $clog2(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [LAT_W-1:0] cnt     [NREG];
    logic             pending [NREG];
    logic             issue;
    logic             wr_track;

    // r0 is hardwired available and never gets an entry.
    assign cnt[0]     = '0;
    assign pending[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        logic zero;

        sb_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .clk    (clk),
            .reset  (reset),
            .load   (wr_track && (id_wr_addr == AW'(r))),
            .lat    (id_lat),
            .cnt    (cnt[r]),
            .zero_c (zero)
        );

        assign pending[r] = ~zero;
    end

    // Hazards only see registered state, so a self-referencing instruction never blocks itself.
    always_comb begin
        rs_hazard  = ~reset & id_valid & id_rs_used & (id_rs_addr != '0)
                   & (cnt[id_rs_addr] != '0);
        rt_hazard  = ~reset & id_valid & id_rt_used & (id_rt_addr != '0)
                   & (cnt[id_rt_addr] != '0);
        waw_hazard = ~reset & id_valid & id_wr_en & (id_wr_addr != '0)
                   & (cnt[id_wr_addr] > id_lat);
        stall      = reset | (~id_flush & (rs_hazard | rt_hazard | waw_hazard));
        issue      = id_valid & ~stall & ~id_flush & ~reset;
        wr_track   = issue & id_wr_en & (id_wr_addr != '0);
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned r = 0; r < NREG; r++) begin
            busy = busy | pending[r];
        end
    end

    // Saturating performance counter of cycles a valid instruction was held.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && id_valid && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/scoreboard_stall_unit.md
SCOREBOARD_STALL_UNIT -- requirements
Module: scoreboard_stall_unit

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning architectural register count (power of 2).
REQ-002 SHALL have parameter LAT_W, default 3, meaning width of per-register latency counter (max latency 2^LAT_W-1).
REQ-003 SHALL have parameter CNT_W, default 32, meaning stall-cycle performance counter width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port id_valid  input  1  ID stage holds a valid instruction.
REQ-007 SHALL have ports id_rs_addr, id_rt_addr  input  log2(NREG) each  source register numbers.
REQ-008 SHALL have ports id_rs_used, id_rt_used  input  1 each  source actually read.
REQ-009 SHALL have port id_wr_en  input  1  instruction writes a destination.
REQ-010 SHALL have port id_wr_addr  input  log2(NREG)  destination register.
REQ-011 SHALL have port id_lat  input  LAT_W  cycles until result is forwardable (ALU=1, load=2, mul=4).
REQ-012 SHALL have port id_flush  input  1  kill ID instruction this cycle.
REQ-013 SHALL have port stall  output  1  1 = hold PC/IF/ID, insert bubble into EX.
REQ-014 SHALL have ports rs_hazard, rt_hazard, waw_hazard  output  1 each  hazard cause flags.
REQ-015 SHALL have port busy  output  1  any register has a pending write.
REQ-016 SHALL have port stall_cycles  output  CNT_W  saturating count of cycles with stall=1 and id_valid=1.

Function
REQ-017 SHALL keep one LAT_W-bit counter cnt[r] per register r; cnt[r]=0 means value available/forwardable.
REQ-018 SHALL never track register 0: cnt[0] constant 0, writes to r0 ignored.
REQ-019 SHALL assert rs_hazard combinationally when id_valid & id_rs_used & id_rs_addr!=0 & cnt[id_rs_addr]!=0; rt_hazard likewise.
REQ-020 SHALL assert waw_hazard when id_valid & id_wr_en & id_wr_addr!=0 & cnt[id_wr_addr] > id_lat (preserves in-order completion).
REQ-021 SHALL drive stall = reset | (~id_flush & (rs_hazard | rt_hazard | waw_hazard)).
REQ-022 SHALL define issue = id_valid & ~stall & ~id_flush & ~reset.
REQ-023 SHALL, each cycle, decrement every nonzero cnt[r] by 1, saturating at 0.
REQ-024 SHALL, on issue with id_wr_en & id_wr_addr!=0, load cnt[id_wr_addr] <= id_lat on the next edge; load overrides decrement of that register.
REQ-025 SHALL treat id_lat=0 as no tracking (result available in the same cycle as issue).
REQ-026 SHALL not issue or update any counter from a flushed instruction; in-flight counters continue decrementing unaffected by flush.
REQ-027 SHALL give stall a release latency of exactly cnt[src] cycles after the producer issues (e.g. load lat 2 -> dependent stalls 2 cycles then issues).
REQ-028 SHALL drive busy = OR of all cnt[r]!=0 (registered state only, not the current ID instruction).
REQ-029 SHALL increment stall_cycles when stall & id_valid & ~reset, holding at 2^CNT_W-1 on saturation.
REQ-030 SHALL let an instruction whose source equals its own destination be checked only against prior state (no self-hazard).

Reset
REQ-031 SHALL, on a clock edge with reset=1, clear all cnt[r] to 0 and stall_cycles to 0.
REQ-032 SHALL hold stall=1 and all hazard flags=0 while reset=1; busy=0 the cycle after reset.
REQ-033 SHALL abandon in-flight latencies when reset is asserted mid-operation (no residual stall after release).

Structure
REQ-034 SHALL take LAT_W default and latency constants LAT_ALU=1, LAT_LOAD=2, LAT_MUL=4 from shared package pipe_pkg.
REQ-035 SHALL instantiate sub-module sb_entry (one countdown counter with load/decrement/zero flag) NREG-1 times.

Verification
REQ-036 SHALL test load-use: issue lw r8 lat 2, next add r9,r8,r1 -> stall=1, rs_hazard=1 for 2 cycles, issue on 3rd; stall_cycles=2.
REQ-037 SHALL test ALU back-to-back: add r3 lat 1 then sub r4,r3,r3 -> stall 1 cycle, rs_hazard and rt_hazard both 1.
REQ-038 SHALL test WAW: mul r5 lat 4, next addi r5 lat 1 -> waw_hazard=1 until cnt[r5]<=1 (3 cycles stall).
REQ-039 SHALL test r0 and unused sources: writes to r0 lat 7, readers of r0 or rt_used=0 on r0 -> stall never asserted, busy=0.
REQ-040 SHALL test flush: hazard present with id_flush=1 -> stall=0, no counter loaded; pending cnt keeps decrementing.
REQ-041 SHALL test reset mid-operation: cnt[r7]=4, assert reset 1 cycle -> stall=1 during reset, afterwards reader of r7 issues with no stall, stall_cycles=0.
